// File: rtl/stack_spill.sv
// Register-cached stack with background spill/fill to a synchronous RAM.
// The CPU sees the top entry; the bottom of the cache drifts to and from RAM.
module stack_spill #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 6,
    parameter int HI    = DEPTH - 2,
    parameter int LO    = 2
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             we,
    input  logic [1:0]       delta,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd,
    output logic             stall,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_re,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [AW+1:0]    depth,
    output logic             ovf,
    output logic             unf
);

    localparam int MEMD = 1 << AW;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int IW   = $clog2(DEPTH);
    localparam int MW   = AW + 1;

    typedef enum logic {IDLE, FILL_WAIT} st_t;

    logic [WIDTH-1:0] ent_q [DEPTH];
    logic [WIDTH-1:0] ent_d [DEPTH];
    logic [CW-1:0]    c_q, c_d;
    logic [MW-1:0]    m_q, m_d;
    st_t              st_q, st_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic push, pop, in_fw, c_full, c_one, m_full, m_zero;
    logic mv_acc, spill_go, fill_go, ovf_hit, unf_hit;
    logic [IW-1:0] sp_idx, fl_idx;

    assign push   = (delta == 2'b01);
    assign pop    = (delta == 2'b11);
    assign in_fw  = (st_q == FILL_WAIT);
    assign c_full = (c_q == CW'(DEPTH));
    assign c_one  = (c_q == CW'(1));
    assign m_full = (m_q == MW'(MEMD));
    assign m_zero = (m_q == '0);

    assign stall = (push & c_full & ~m_full)
                 | (pop & c_one & ~m_zero)
                 | (delta[0] & in_fw);

    assign mv_acc   = delta[0] & ~stall;
    assign ovf_hit  = mv_acc & push & c_full & m_full;
    assign unf_hit  = mv_acc & pop & (c_q == '0) & m_zero;

    // The CPU owns the cycle whenever it moves; background work waits.
    assign spill_go = ~in_fw & ~mv_acc & (c_q >= CW'(HI)) & ~m_full;
    assign fill_go  = ~in_fw & ~mv_acc & ~spill_go
                    & (c_q <= CW'(LO)) & ~m_zero;

    assign sp_idx = IW'(c_q - 1'b1);
    assign fl_idx = IW'(c_q);

    assign rd        = ent_q[0];
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign depth     = (AW+2)'(c_q) + (AW+2)'(m_q);
    assign mem_we    = spill_go;
    assign mem_re    = fill_go;
    assign mem_wdata = spill_go ? ent_q[sp_idx] : '0;

    always_comb begin
        mem_addr = '0;
        if (spill_go)
            mem_addr = AW'(m_q);
        else if (fill_go)
            mem_addr = AW'(m_q - 1'b1);
    end

    always_comb begin
        ent_d = ent_q;
        c_d   = c_q;
        m_d   = m_q;
        st_d  = st_q;
        ovf_d = ovf_q;
        unf_d = unf_q;

        if (ovf_hit) begin
            ovf_d = 1'b1;
        end else if (unf_hit) begin
            unf_d = 1'b1;
        end else if (mv_acc && push) begin
            for (int i = DEPTH - 1; i > 0; i--)
                ent_d[i] = ent_q[i-1];
            ent_d[0] = we ? wd : ent_q[0];
            c_d = c_q + 1'b1;
        end else if (mv_acc && pop) begin
            for (int i = 0; i < DEPTH - 1; i++)
                ent_d[i] = ent_q[i+1];
            ent_d[DEPTH-1] = '0;
            // Entries above c are stale, so the last pop yields zero.
            ent_d[0] = we ? wd : (c_one ? '0 : ent_q[1]);
            c_d = c_q - 1'b1;
        end else if (we) begin
            ent_d[0] = wd;
        end

        if (spill_go) begin
            c_d = c_q - 1'b1;
            m_d = m_q + 1'b1;
        end

        if (fill_go)
            st_d = FILL_WAIT;

        if (in_fw) begin
            ent_d[fl_idx] = mem_rdata;
            c_d  = c_q + 1'b1;
            m_d  = m_q - 1'b1;
            st_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            for (int i = 0; i < DEPTH; i++)
                ent_q[i] <= '0;
            c_q   <= '0;
            m_q   <= '0;
            st_q  <= IDLE;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ent_q <= ent_d;
            c_q   <= c_d;
            m_q   <= m_d;
            st_q  <= st_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

endmodule

// File: tb/tb_stack_spill.sv
// Scoreboard bench for stack_spill against a logical-stack reference model.
// The spill RAM is a plain synchronous memory in the bench.
module tb_stack_spill;

    localparam int D    = 16;
    localparam int MEMD = 64;
    localparam int HI   = D - 2;
    localparam int LO   = 2;

    logic        clk;
    logic        resetq;
    logic        we;
    logic [1:0]  delta;
    logic [15:0] wd;
    logic [15:0] rd;
    logic        stall;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic [7:0]  depth;
    logic        ovf;
    logic        unf;

    stack_spill dut (
        .clk(clk), .resetq(resetq), .we(we), .delta(delta), .wd(wd),
        .rd(rd), .stall(stall), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .depth(depth), .ovf(ovf), .unf(unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] ram [MEMD];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    typedef struct packed {
        logic        stall;
        logic [15:0] rd;
        logic [7:0]  depth;
        logic        mwe;
        logic        mre;
        logic [5:0]  maddr;
        logic [15:0] mwd;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int fails  = 0;

    // Reference: whole logical stack as a queue, s[0] is the top.
    logic [15:0] s[$];
    logic [15:0] etop;
    int  n, c, m;
    bit  fw, movf, munf;

    function automatic logic [15:0] top();
        return (n > 0) ? s[0] : etop;
    endfunction

    task automatic model_reset();
        s.delete();
        etop = 0; n = 0; c = 0; m = 0;
        fw = 0; movf = 0; munf = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            fails++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, ex, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", 32'(stall), 32'(e.stall));
            chk("rd", 32'(rd), 32'(e.rd));
            chk("depth", 32'(depth), 32'(e.depth));
            chk("mem_we", 32'(mem_we), 32'(e.mwe));
            chk("mem_re", 32'(mem_re), 32'(e.mre));
            chk("ovf", 32'(ovf), 32'(e.ovf));
            chk("unf", 32'(unf), 32'(e.unf));
            if (e.mwe || e.mre)
                chk("mem_addr", 32'(mem_addr), 32'(e.maddr));
            if (e.mwe)
                chk("mem_wdata", 32'(mem_wdata), 32'(e.mwd));
        end
    end

    task automatic step(input logic w, input logic [1:0] d,
                        input logic [15:0] v, output bit stl);
        bit ps, pp, mv, acc, spl, fil;
        exp_t e;
        we = w; delta = d; wd = v;
        ps = (d == 2'b01);
        pp = (d == 2'b11);
        mv = d[0];
        stl = (ps && c == D && m < MEMD) || (pp && c == 1 && m > 0)
            || (mv && fw);
        acc = mv && !stl;
        spl = !fw && !acc && c >= HI && m < MEMD;
        fil = !fw && !acc && !spl && c <= LO && m > 0;
        e = '0;
        e.stall = stl;
        e.rd    = top();
        e.depth = 8'(n);
        e.mwe   = spl;
        e.mre   = fil;
        e.ovf   = movf;
        e.unf   = munf;
        if (spl) begin
            e.maddr = 6'(m);
            e.mwd   = s[c-1];
        end
        if (fil) e.maddr = 6'(m - 1);
        exp_q.push_back(e);
        @(posedge clk);
        if (fw) begin
            c++; m--; fw = 0;
        end
        if (acc && ps && n == D + MEMD) begin
            movf = 1;
        end else if (acc && pp && n == 0) begin
            munf = 1;
        end else if (acc && ps) begin
            s.push_front(w ? v : top());
            n++; c++;
        end else if (acc && pp) begin
            void'(s.pop_front());
            n--; c--;
            if (n > 0) begin
                if (w) s[0] = v;
            end else begin
                etop = w ? v : 16'h0;
            end
        end else if (w) begin
            if (n > 0) s[0] = v;
            else etop = v;
        end
        if (spl) begin
            c--; m++;
        end
        if (fil) fw = 1;
        #1;
    endtask

    task automatic do_op(input logic w, input logic [1:0] d,
                         input logic [15:0] v);
        bit stl;
        int k = 0;
        do begin
            step(w, d, v, stl);
            k++;
        end while (stl && k < 4);
        checks++;
        if (stl) begin
            fails++;
            $display("FAIL stall_bound got=%0d want<=3 t=%0t", k, $time);
        end
    endtask

    task automatic idle(input int k);
        bit stl;
        for (int i = 0; i < k; i++) step(1'b0, 2'b00, 16'h0, stl);
    endtask

    task automatic reset_seq();
        exp_t e;
        resetq = 1'b0;
        we = 0; delta = 0; wd = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            e = '0;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        resetq = 1'b1;
    endtask

    initial begin
        bit stl;
        int k;
        resetq = 1'b0;
        we = 0; delta = 0; wd = 0;
        model_reset();
        @(posedge clk);
        #1;
        reset_seq();
        idle(5);

        // Spill on the first idle cycle after 14 pushes.
        for (int i = 1; i <= 14; i++) do_op(1'b1, 2'b01, 16'(i));
        idle(2);

        // Stall on the 17th push, then pop everything back out.
        reset_seq();
        for (int i = 1; i <= 17; i++) do_op(1'b1, 2'b01, 16'(i));
        idle(1);
        for (int i = 0; i < 17; i++) do_op(1'b0, 2'b11, 16'h0);
        idle(3);

        // Fill up to DEPTH+MEMD, then overflow.
        reset_seq();
        for (int i = 0; i < D + MEMD; i++)
            do_op(1'b1, 2'b01, 16'($urandom));
        do_op(1'b1, 2'b01, 16'hBEEF);
        idle(2);

        // Underflow on empty.
        reset_seq();
        do_op(1'b1, 2'b11, 16'h1234);
        idle(2);

        // Randomised traffic, push-biased then pop-biased.
        reset_seq();
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 400; i++) begin
                int r = $urandom_range(0, 9);
                logic w = 1'($urandom);
                logic [15:0] v = 16'($urandom);
                if (ph == 0 ? r < 5 : r < 2)
                    do_op(w, 2'b01, v);
                else if (ph == 0 ? r < 7 : r < 7)
                    do_op(w, 2'b11, v);
                else if (r < 8)
                    do_op(1'b1, 2'b00, v);
                else
                    do_op(1'b0, {1'($urandom), 1'b0}, v);
            end
        end
        idle(3);

        // Reset while a fill is outstanding.
        reset_seq();
        for (int i = 1; i <= 15; i++) do_op(1'b1, 2'b01, 16'(i + 100));
        idle(3);
        k = 0;
        while (!fw && k < 40) begin
            step(1'b0, 2'b11, 16'h0, stl);
            k++;
        end
        checks++;
        if (!fw) begin
            fails++;
            $display("FAIL fill_reach got=0 want=1 t=%0t", $time);
        end
        reset_seq();
        idle(4);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/stack_spill.md
Name: stack_spill

Overview:
- Bottom-end service engine for the CPU's data/return stacks. The CPU still drives the top through the usual push/pop/write interface (we, delta, wd, rd).
- The block holds a DEPTH-entry register cache. It spills the bottom entries to an external synchronous RAM when the cache runs high and refills from that RAM when the cache runs low.
- The stack therefore looks DEPTH+2^AW entries deep. `stall` is raised only when the cache alone cannot satisfy a move.

Parameters:
- WIDTH, 16, entry width in bits.
- DEPTH, 16, register cache entries (≥4).
- AW, 6, spill RAM address width; MEMD = 2^AW spill slots.
- HI, DEPTH-2, spill watermark. Spill is eligible when c ≥ HI.
- LO, 2, fill watermark. Fill is eligible when c ≤ LO. Must satisfy 1 ≤ LO < HI.

Ports:
- clk  in  1  clock, rising edge.
- resetq  in  1  asynchronous active-low reset.
- we  in  1  write wd into the top entry.
- delta  in  2  move: 01 = push, 11 = pop, 00/10 = no move.
- wd  in  WIDTH  write data.
- rd  out  WIDTH  top entry (cache entry 0).
- stall  out  1  move not accepted this cycle; CPU must hold we/delta/wd.
- mem_addr  out  AW  spill RAM address.
- mem_we  out  1  spill RAM write strobe.
- mem_wdata  out  WIDTH  spill RAM write data.
- mem_re  out  1  spill RAM read strobe.
- mem_rdata  in  WIDTH  read data, valid on the cycle after mem_re.
- depth  out  AW+2  total entries, c+m.
- ovf  out  1  sticky overflow.
- unf  out  1  sticky underflow.

Behaviour:
- State:
  - cache entry[0..DEPTH-1], where entry[0] is the top;
  - c = cached count (0..DEPTH);
  - m = spilled count (0..MEMD);
  - FSM state is IDLE or FILL_WAIT.
- Invariant: m>0 implies c≥1.
- Reset (async, resetq low): all entries 0, c=0, m=0, IDLE, ovf=0, unf=0. Outputs during reset: rd=0, stall=0, mem_we=0, mem_re=0, depth=0.
- stall is combinational and asserted when any of these holds:
  - push and c==DEPTH and m<MEMD;
  - pop and c==1 and m>0;
  - delta[0]=1 and state==FILL_WAIT.
- An accepted operation is one with stall=0; it takes effect at the clock edge.
  - Push: entries shift down by one, entry[0] = (we ? wd : entry[0]), c++.
  - Pop: entries shift up by one, entry[0] = (we ? wd : old entry[1]), c--.
  - we with no move: entry[0] = wd; c unchanged.
- Overflow: push with c+m == DEPTH+MEMD sets ovf. The push is dropped (no state change) and stall stays 0.
- Underflow: pop with c+m == 0 sets unf. The pop is dropped and any accompanying we is ignored.
- Pop with c==1 and m==0 is legal: c becomes 0 and entry[0] becomes (we ? wd : 0).
- Spill (single cycle, IDLE only):
  - Condition: c ≥ HI, m < MEMD, and no move accepted this cycle.
  - Outputs that cycle: mem_we=1, mem_addr=m, mem_wdata=entry[c-1].
  - At the edge: c--, m++.
  - A we-only write to entry[0] in the same cycle is permitted.
- Fill:
  - Trigger: in IDLE with c ≤ LO, m > 0, no spill pending and no move accepted.
  - Issue cycle: mem_re=1, mem_addr=m-1; go to FILL_WAIT.
  - FILL_WAIT (exactly 1 cycle): entry[c] = mem_rdata, c++, m--, return to IDLE.
  - CPU moves are stalled during FILL_WAIT; we-only writes are accepted.
- Spill and fill are mutually exclusive because LO < HI. The CPU always has priority over a background spill or fill.
- A stalled move is resolved within 1 cycle (spill) or 2 cycles (fill) of stall rising.
- mem_we and mem_re are never high together and are 0 outside the cases above.
- Reset asserted during FILL_WAIT aborts the fill; the returning mem_rdata is ignored.

Test Plan:
- Reset then idle 5 cycles -> rd=0, depth=0, stall=0, mem_we=mem_re=0, ovf=unf=0.
- Push 1..14 back-to-back, then 1 idle cycle -> spill on the idle cycle with mem_we=1, mem_addr=0, mem_wdata=1; afterwards c=13, m=1, depth=14.
- Push 1..17 back-to-back:
  - expected: stall=1 on the 17th push for exactly 1 cycle; spill writes value 1 to address 0; push 17 is accepted on the next cycle; rd=17, depth=17.
- From the depth=17 state, pop continuously until depth=0:
  - rd sequence is 16,15,…,1 with no lost or duplicated values;
  - fills issue mem_re at addresses m-1 in descending order;
  - each stall lasts ≤2 cycles.
- Push 80 values to reach DEPTH+MEMD, then push 0xBEEF -> ovf=1, rd and depth unchanged. Pop on empty after reset -> unf=1, rd=0.
- Pulse resetq low during FILL_WAIT -> c=m=0, IDLE, rd=0 immediately; the stale mem_rdata is not loaded.
